rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter KEY_LENGTH, default 32: number of key bytes loaded.
REQ-002 SHALL have parameter ROM_LENGTH, default 5: ROM address width in bits.
REQ-003 SHALL have parameter ROM_WIDTH, default 8: ROM data and key byte width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port start  input  1: load request, level-sensitive, sampled only in IDLE.
REQ-007 SHALL have port rom_out  input  ROM_WIDTH: ROM read data.
REQ-008 SHALL have port address  output  ROM_LENGTH: ROM read address, registered.
REQ-009 SHALL have port key_arr  output  packed [KEY_LENGTH-1:0][ROM_WIDTH-1:0]: loaded key; key_arr[i] = ROM[i].
REQ-010 SHALL have port finished  output  1: load complete.
REQ-011 SHALL have port state_tap  output  3: current FSM state encoding for debug.

Function
REQ-012 SHALL implement FSM states IDLE=3'b000, FETCH=3'b001, WAIT=3'b010, READ=3'b011, DONE=3'b100.
REQ-013 SHALL use an index counter idx of width $clog2(KEY_LENGTH)+1; address = idx[ROM_LENGTH-1:0].
REQ-014 In IDLE with start=1, SHALL go to FETCH with idx=0; with start=0, SHALL stay in IDLE.
REQ-015 FETCH SHALL drive address=idx and go to WAIT; WAIT SHALL go to READ unconditionally.
REQ-016 The FETCH-WAIT-READ sequence SHALL tolerate ROM read latency of 1 or 2 cycles.
REQ-017 READ SHALL capture rom_out into key_arr[idx]; if idx==KEY_LENGTH-1 it SHALL go to DONE, else increment idx and go to FETCH.
REQ-018 The load SHALL take exactly 3*KEY_LENGTH cycles from the edge sampling start to the first cycle with finished=1 (96 at defaults).
REQ-019 finished SHALL be 1 exactly when state==DONE.
REQ-020 In DONE, SHALL stay while start=1 and return to IDLE on the first edge with start=0.
REQ-021 Deasserting start during FETCH/WAIT/READ SHALL NOT abort the load.
REQ-022 A new load SHALL overwrite key_arr entries in order; entries not yet rewritten SHALL hold prior values.
REQ-023 key_arr SHALL be stable outside READ cycles.
REQ-024 Addresses SHALL be issued in strictly ascending order 0..KEY_LENGTH-1 with no skips or repeats.

Reset
REQ-025 With reset=0 at a rising edge, the block SHALL set state=IDLE, idx=0, address=0, key_arr all zero, finished=0, state_tap=3'b000.
REQ-026 Reset SHALL take priority over all other inputs, including mid-load, and the next load SHALL restart at address 0.

Configuration
REQ-027 With macro ROM_LOADER_STATE_TAP_EN defined, state_tap SHALL equal the state encoding; when undefined, state_tap SHALL be tied to 3'b000 and the other behaviour SHALL be unchanged.

Structure
REQ-028 Package rom_loader_pkg SHALL hold the state enum typedef (3-bit) and the state encoding constants.
REQ-029 The block SHALL be one flat module; no sub-module is warranted.

Verification
REQ-030 rom_out fixed 8'h01, reset pulse, start=1 held -> address steps 0..31, finished=1 after 96 cycles, all 32 key_arr bytes = 8'h01, finished held while start=1.
REQ-031 ROM model returning data = address+8'h10 with 1-cycle latency, and again with 2-cycle latency -> key_arr[i] = i+8'h10 for i=0..31 in both cases.
REQ-032 In DONE, start=0 for 20 cycles then start=1 -> finished drops the next cycle, state_tap=000, a second full load runs, and finished returns after 96 cycles.
REQ-033 reset=0 for one edge at address 10 -> key_arr all 0, finished=0, state_tap=000; a subsequent start reloads from address 0.
REQ-034 One-cycle start pulse -> full load completes, finished=1 for exactly one cycle, then IDLE.
REQ-035 Build without ROM_LOADER_STATE_TAP_EN -> state_tap constant 3'b000 and key/finished timing identical to REQ-030.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// ==========================================================================
// rom_loader_pkg : state type and encodings shared by the ROM key loader
// Revision: 1.0
// ==========================================================================
`default_nettype none

package rom_loader_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'b000,
    FETCH = 3'b001,
    WAIT  = 3'b010,
    READ  = 3'b011,
    DONE  = 3'b100
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rom_loader.sv
// ==========================================================================
// rom_loader : copies KEY_LENGTH words from a ROM into a packed key array.
// Optional macro ROM_LOADER_STATE_TAP_EN exposes the FSM state on state_tap.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int KEY_LENGTH = 32,
  parameter int ROM_LENGTH = 5,
  parameter int ROM_WIDTH  = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [ROM_WIDTH-1:0]                 rom_out,
  output logic [ROM_LENGTH-1:0]                address,
  output logic [KEY_LENGTH-1:0][ROM_WIDTH-1:0] key_arr,
  output logic                                 finished,
  output logic [2:0]                           state_tap
);

  localparam int IDX_W = $clog2(KEY_LENGTH) + 1;
  localparam int SEL_W = $clog2(KEY_LENGTH);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             capture;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          idx_next   = '0;
        end
      end
      FETCH: state_next = WAIT;
      WAIT:  state_next = READ;
      READ: begin
        capture = 1'b1;
        if (idx == IDX_W'(KEY_LENGTH - 1)) begin
          state_next = DONE;
        end else begin
          idx_next   = idx + IDX_W'(1);
          state_next = FETCH;
        end
      end
      DONE: begin
        if (!start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address moves together with idx on entry to FETCH, so it is stable for
  // FETCH, WAIT and READ; data up to two cycles late is still caught in READ.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      address <= '0;
      key_arr <= '0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      address <= idx_next[ROM_LENGTH-1:0];
      if (capture) key_arr[idx[SEL_W-1:0]] <= rom_out;
    end
  end

  assign finished = (state == DONE);

`ifdef ROM_LOADER_STATE_TAP_EN
  assign state_tap = state;
`else
  assign state_tap = 3'b000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
// ==========================================================================
// tb_rom_loader : directed self-checking bench for rom_loader
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_rom_loader;

  logic            clk;
  logic            reset;
  logic            start;
  logic [7:0]      rom_out;
  logic [4:0]      address;
  logic [31:0][7:0] key_arr;
  logic            finished;
  logic [2:0]      state_tap;

  int checks = 0;
  int errors = 0;

  // 0: constant 8'h01, 1: address+8'h10 after 1 cycle, 2: after 2 cycles
  int        rom_mode = 0;
  logic [7:0] d1, d2;

`ifdef ROM_LOADER_STATE_TAP_EN
  localparam logic [2:0] TAP_DONE = 3'b100;
`else
  localparam logic [2:0] TAP_DONE = 3'b000;
`endif

  rom_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rom_out  (rom_out),
    .address  (address),
    .key_arr  (key_arr),
    .finished (finished),
    .state_tap(state_tap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= {3'b000, address} + 8'h10;
    d2 <= d1;
  end

  always_comb begin
    rom_out = 8'h01;
    if (rom_mode == 1) rom_out = d1;
    else if (rom_mode == 2) rom_out = d2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a load from IDLE; n counts edges after the one sampling start.
  task automatic run_load(input bit pulse, output int fin_cycle, output int addr_bad);
    int exp_addr;
    fin_cycle = -1;
    addr_bad  = 0;
    start     = 1'b1;
    for (int n = 0; n < 200; n++) begin
      step();
      if (pulse && n == 0) start = 1'b0;
      exp_addr = (n < 96) ? n / 3 : 31;
      if (address !== 5'(exp_addr)) addr_bad++;
      if (finished === 1'b1) begin
        fin_cycle = n;
        break;
      end
    end
  endtask

  function automatic logic [31:0][7:0] exp_keys(input int mode);
    logic [31:0][7:0] k;
    for (int i = 0; i < 32; i++) k[i] = (mode == 0) ? 8'h01 : 8'(i + 16);
    return k;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    step();
    reset = 1'b1;
    checks++; if (address !== 5'd0) begin errors++; $display("FAIL reset_address got %h want 00", address); end
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL reset_finished got %b want 0", finished); end
    checks++; if (state_tap !== 3'b000) begin errors++; $display("FAIL reset_tap got %b want 000", state_tap); end
    checks++; if (key_arr !== '0) begin errors++; $display("FAIL reset_keys got %h want 0", key_arr); end
  endtask

  task automatic test_fixed_load();
    int fin, bad, held_bad;
    rom_mode = 0;
    run_load(1'b0, fin, bad);
    checks++; if (fin !== 96) begin errors++; $display("FAIL fixed_latency got %0d want 96", fin); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fixed_address_seq got %0d bad want 0", bad); end
    checks++; if (key_arr !== exp_keys(0)) begin errors++; $display("FAIL fixed_keys got %h want %h", key_arr, exp_keys(0)); end
    checks++; if (state_tap !== TAP_DONE) begin errors++; $display("FAIL done_tap got %b want %b", state_tap, TAP_DONE); end
    held_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (finished !== 1'b1) held_bad++;
    end
    checks++; if (held_bad !== 0) begin errors++; $display("FAIL finished_held got %0d drops want 0", held_bad); end
  endtask

  task automatic test_rom_latency(input int mode);
    int fin, bad;
    start = 1'b0;
    step();
    rom_mode = mode;
    run_load(1'b0, fin, bad);
    checks++; if (fin !== 96) begin errors++; $display("FAIL lat%0d_latency got %0d want 96", mode, fin); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL lat%0d_address_seq got %0d bad want 0", mode, bad); end
    checks++; if (key_arr !== exp_keys(1)) begin errors++; $display("FAIL lat%0d_keys got %h want %h", mode, key_arr, exp_keys(1)); end
  endtask

  task automatic test_restart_after_idle();
    int fin, bad, idle_bad;
    rom_mode = 1;
    start = 1'b0;
    step();
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL idle_finished got %b want 0", finished); end
    checks++; if (state_tap !== 3'b000) begin errors++; $display("FAIL idle_tap got %b want 000", state_tap); end
    idle_bad = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (finished !== 1'b0 || key_arr !== exp_keys(1)) idle_bad++;
    end
    checks++; if (idle_bad !== 0) begin errors++; $display("FAIL idle_stable got %0d bad want 0", idle_bad); end
    run_load(1'b0, fin, bad);
    checks++; if (fin !== 96) begin errors++; $display("FAIL reload_latency got %0d want 96", fin); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reload_address_seq got %0d bad want 0", bad); end
  endtask

  task automatic test_reset_mid_load();
    int fin, bad, n;
    logic [31:0][7:0] k;
    start = 1'b0;
    step();
    rom_mode = 0;
    start = 1'b1;
    n = 0;
    while (address !== 5'd10 && n < 100) begin
      step();
      n++;
    end
    checks++; if (n !== 31) begin errors++; $display("FAIL mid_reach_addr10 got %0d cycles want 31", n); end
    k = exp_keys(1);
    for (int i = 0; i < 10; i++) k[i] = 8'h01;
    checks++; if (key_arr !== k) begin errors++; $display("FAIL partial_overwrite got %h want %h", key_arr, k); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    start = 1'b0;
    checks++; if (key_arr !== '0) begin errors++; $display("FAIL mid_reset_keys got %h want 0", key_arr); end
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL mid_reset_finished got %b want 0", finished); end
    checks++; if (state_tap !== 3'b000) begin errors++; $display("FAIL mid_reset_tap got %b want 000", state_tap); end
    checks++; if (address !== 5'd0) begin errors++; $display("FAIL mid_reset_address got %h want 00", address); end
    run_load(1'b0, fin, bad);
    checks++; if (fin !== 96) begin errors++; $display("FAIL after_reset_latency got %0d want 96", fin); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL after_reset_address_seq got %0d bad want 0", bad); end
    checks++; if (key_arr !== exp_keys(0)) begin errors++; $display("FAIL after_reset_keys got %h want %h", key_arr, exp_keys(0)); end
  endtask

  task automatic test_start_pulse();
    int fin, bad;
    start = 1'b0;
    step();
    rom_mode = 2;
    run_load(1'b1, fin, bad);
    checks++; if (fin !== 96) begin errors++; $display("FAIL pulse_latency got %0d want 96", fin); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pulse_address_seq got %0d bad want 0", bad); end
    checks++; if (key_arr !== exp_keys(2)) begin errors++; $display("FAIL pulse_keys got %h want %h", key_arr, exp_keys(2)); end
    step();
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL pulse_finished_width got %b want 0", finished); end
    checks++; if (state_tap !== 3'b000) begin errors++; $display("FAIL pulse_idle_tap got %b want 000", state_tap); end
    step();
    checks++; if (finished !== 1'b0 || address !== 5'd31) begin
      errors++; $display("FAIL pulse_stay_idle got fin=%b addr=%h want fin=0 addr=1f", finished, address);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_fixed_load();
    test_rom_latency(1);
    test_rom_latency(2);
    test_restart_after_idle();
    test_reset_mid_load();
    test_start_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
